pwm_duty_decoder: RTL and testbench

- Receive-side counterpart to the team's PWM generator. Samples an external PWM waveform on clk_3125KHz.
- Measures high time over each complete rising-edge-to-rising-edge period and reports it as a 4-bit duty code in the generator's encoding (high cycles per 16-cycle frame).
- Flags malformed periods and stuck lines. Used for loopback self-test and for decoding PWM from external sources.

---
 rtl/pwm_duty_decoder_pkg.sv | 13 +
 rtl/pwm_in_sync.sv | 34 +++
 rtl/pwm_duty_decoder.sv | 115 +++++++++++
 tb/tb_pwm_duty_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared PWM constants and the decoder state type. The frame constants are
// also used by pwm_generator so both ends agree on the duty encoding.
package pwm_duty_decoder_pkg;

    localparam int PWM_PERIOD = 16;
    localparam int PWM_DUTY_W = 4;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } dec_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM line into the clk_3125KHz domain and flags
// rising edges of the synchronised level.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_3125KHz,
    input  logic reset,
    input  logic pwm_in,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            // NOTE: flops reset to 1 so a line already high at release is not
            // mistaken for a rising edge.
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its predecessor, which is what makes this a shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures high time per rising-edge-to-rising-edge period of a sampled PWM
// line and reports it as a duty code; flags bad periods and static lines.
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int PERIOD      = PWM_PERIOD,
    parameter int DUTY_W      = PWM_DUTY_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic              clk_3125KHz,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_valid,
    output logic              period_err,
    output logic              stuck_high
);

    localparam int                CNT_W     = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

    logic s;
    logic rise;

    dec_state_e        state_q, state_d;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              stuck_q, stuck_d;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .s_o         (s),
        .rise_o      (rise)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            state_q   <= SEARCH;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            stuck_q   <= stuck_d;
        end
    end

    // Period evaluation on rise, timeout handling, and counter advance.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        stuck_d   = stuck_q;

        if (rise) begin
            stuck_d = 1'b0;
            if (state_q == MEASURE) begin
                if (per_cnt_q == PERIOD_C) begin
                    duty_d  = hi_cnt_q[DUTY_W-1:0];
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            // A bad period drops to SEARCH and re-arms on this same rise,
            // which is the same as landing in MEASURE with fresh counters.
            state_d   = MEASURE;
            per_cnt_d = ONE_C;
            hi_cnt_d  = ONE_C;
        end else if (per_cnt_q == TIMEOUT_C) begin
            if (s) begin
                stuck_d = 1'b1;
            end else begin
                duty_d  = '0;
                valid_d = 1'b1;
            end
            state_d   = SEARCH;
            per_cnt_d = ONE_C;
            hi_cnt_d  = ONE_C;
        end else begin
            per_cnt_d = (per_cnt_q < TIMEOUT_C) ? per_cnt_q + ONE_C : per_cnt_q;
            hi_cnt_d  = hi_cnt_q + CNT_W'(s);
        end
    end

    assign duty_cycle = duty_q;
    assign duty_valid = valid_q;
    assign period_err = err_q;
    assign stuck_high = stuck_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: directed loopback/fault scenarios plus random
// PWM traffic, checked every cycle against a period-level reference model.
module tb_pwm_duty_decoder;

    localparam int SYNC    = 2;
    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 32;

    logic       clk_3125KHz = 1'b0;
    logic       reset       = 1'b1;
    logic       pwm_in      = 1'b0;
    logic [3:0] duty_cycle;
    logic       duty_valid;
    logic       period_err;
    logic       stuck_high;

    int checks     = 0;
    int failures   = 0;
    int valid_seen = 0;
    int err_seen   = 0;

    // Reference model state: delayed view of the line, samples since the
    // last counter reload, and whether the last reload came from a rise.
    bit pipe[$];
    bit per_q[$];
    bit prev_v    = 1'b1;
    bit armed     = 1'b0;
    int exp_duty  = 0;
    bit exp_valid = 1'b0;
    bit exp_err   = 1'b0;
    bit exp_stuck = 1'b0;

    pwm_duty_decoder dut (
        .clk_3125KHz (clk_3125KHz),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .duty_cycle  (duty_cycle),
        .duty_valid  (duty_valid),
        .period_err  (period_err),
        .stuck_high  (stuck_high)
    );

    always #160 clk_3125KHz = ~clk_3125KHz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge, then compare DUT outputs just after it.
    always @(posedge clk_3125KHz) begin
        bit v;
        bit rise;
        int h;
        if (reset) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b1);
            per_q.delete();
            prev_v    = 1'b1;
            armed     = 1'b0;
            exp_duty  = 0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_stuck = 1'b0;
        end else begin
            pipe.push_back(pwm_in);
            v         = pipe.pop_front();
            rise      = v & ~prev_v;
            prev_v    = v;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (rise) begin
                if (armed) begin
                    if (per_q.size() == PERIOD) begin
                        h = 0;
                        foreach (per_q[i]) h += int'(per_q[i]);
                        exp_duty  = h;
                        exp_valid = 1'b1;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                exp_stuck = 1'b0;
                armed     = 1'b1;
                per_q.delete();
                per_q.push_back(v);
            end else if (per_q.size() == TIMEOUT) begin
                if (v) begin
                    exp_stuck = 1'b1;
                end else begin
                    exp_duty  = 0;
                    exp_valid = 1'b1;
                end
                armed = 1'b0;
                per_q.delete();
                per_q.push_back(v);
            end else begin
                per_q.push_back(v);
            end
        end
        #1;
        check("duty_cycle", int'(duty_cycle), exp_duty);
        check("duty_valid", int'(duty_valid), int'(exp_valid));
        check("period_err", int'(period_err), int'(exp_err));
        check("stuck_high", int'(stuck_high), int'(exp_stuck));
        if (duty_valid) valid_seen++;
        if (period_err) err_seen++;
    end

    task automatic drive(input bit b);
        @(negedge clk_3125KHz);
        pwm_in = b;
    endtask

    task automatic hold(input bit b, input int cycles);
        for (int i = 0; i < cycles; i++) drive(b);
    endtask

    task automatic period(input int len, input int hi);
        for (int i = 0; i < len; i++) drive(i < hi);
    endtask

    task automatic frame(input int duty);
        period(PERIOD, duty);
    endtask

    task automatic do_reset();
        @(negedge clk_3125KHz);
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk_3125KHz);
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        valid_seen = 0;
        err_seen   = 0;
    endtask

    initial begin
        #(20_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int len;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk_3125KHz);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_valid", int'(duty_valid), 0);
        check("rst_err", int'(period_err), 0);
        check("rst_stuck", int'(stuck_high), 0);
        reset = 1'b0;

        // Loopback duty 5: first rise arms, each later rise reports.
        clear_counts();
        repeat (10) frame(5);
        check("lb5_duty", int'(duty_cycle), 5);
        check("lb5_valid_cnt", valid_seen, 9);
        check("lb5_err_cnt", err_seen, 0);

        // Duty 3 then 12, back to back frames.
        do_reset();
        clear_counts();
        repeat (6) frame(3);
        repeat (6) frame(12);
        hold(1'b0, 3);
        check("dc312_duty", int'(duty_cycle), 12);
        check("dc312_valid_cnt", valid_seen, 11);
        check("dc312_err_cnt", err_seen, 0);

        // Line held low: timeout reports duty 0, once per TIMEOUT cycles.
        hold(1'b0, 40);
        check("low_duty", int'(duty_cycle), 0);
        clear_counts();
        hold(1'b0, TIMEOUT);
        check("low_valid_cnt", valid_seen, 1);

        // Line held high: stuck_high sets, duty held; next rise clears it.
        do_reset();
        repeat (3) frame(5);
        hold(1'b1, 45);
        check("stuck_set", int'(stuck_high), 1);
        check("stuck_duty", int'(duty_cycle), 5);
        hold(1'b0, 2);
        hold(1'b1, 4);
        check("stuck_clear", int'(stuck_high), 0);

        // Period 20, high 7: each completed long period is an error.
        do_reset();
        repeat (3) frame(5);
        clear_counts();
        repeat (6) period(20, 7);
        hold(1'b0, 3);
        check("p20_valid_cnt", valid_seen, 1);
        check("p20_err_cnt", err_seen, 5);
        check("p20_duty", int'(duty_cycle), 5);

        // Reset mid-frame with the line high, released while still high.
        do_reset();
        repeat (2) frame(9);
        hold(1'b1, 4);
        #50;
        reset = 1'b1;
        clear_counts();
        hold(1'b1, 2);
        reset = 1'b0;
        hold(1'b1, 3);
        hold(1'b0, 7);
        check("mid_rst_valid_cnt", valid_seen, 0);
        check("mid_rst_err_cnt", err_seen, 0);
        check("mid_rst_duty", int'(duty_cycle), 0);
        check("mid_rst_stuck", int'(stuck_high), 0);
        repeat (3) frame(9);
        hold(1'b0, 3);
        check("mid_rst_valid_after", valid_seen, 2);
        check("mid_rst_duty_after", int'(duty_cycle), 9);

        // Random traffic: good frames, odd periods (incl. length 32 where
        // rise and timeout coincide), static stretches and resets.
        do_reset();
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                frame($urandom_range(1, PERIOD - 1));
            end else if (r < 85) begin
                len = $urandom_range(8, 34);
                period(len, $urandom_range(1, len - 1));
            end else if (r < 95) begin
                hold(1'($urandom_range(0, 1)), $urandom_range(20, 70));
            end else begin
                do_reset();
            end
        end
        hold(1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
